rtc_tstamp_core: RTL and testbench

RTC_TSTAMP_CORE -- requirements
Module: rtc_tstamp_core

---
 rtl/rtc_pkg.sv | 27 ++
 rtl/rtc_capt_chan.sv | 77 +++++++
 rtl/rtc_tstamp_core.sv | 159 +++++++++++++++
 tb/tb_rtc_tstamp_core.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC timestamp core.
// Contents:
//   NS_PER_SEC, NS_HALF_SEC : nanosecond rollover and PPS threshold
//   INCR_INT_W, SEC_MAX_W   : integer-ns bits of the increment, widest seconds counter
//   incr_width()            : total width of the fixed-point per-cycle increment
//   capt_rec_t              : one capture record {sec, nsec, valid, ovf}
package rtc_pkg;

    localparam int unsigned NS_PER_SEC  = 32'd1_000_000_000;
    localparam int unsigned NS_HALF_SEC = 32'd500_000_000;
    localparam int unsigned INCR_INT_W  = 8;
    localparam int unsigned SEC_MAX_W   = 48;

    // Increment is unsigned fixed point: INCR_INT_W integer ns bits over frac_w fraction bits.
    function automatic int unsigned incr_width(input int unsigned frac_w);
        return INCR_INT_W + frac_w;
    endfunction

    // Seconds held at the widest legal width; channels narrow it on output.
    typedef struct packed {
        logic [SEC_MAX_W-1:0] sec;
        logic [31:0]          nsec;
        logic                 valid;
        logic                 ovf;
    } capt_rec_t;

endpackage

// File: rtl/rtc_capt_chan.sv
// One timestamp capture channel.
// A 2-FF synchroniser feeds a rising-edge detector. A detected edge latches the
// current time and sets capt_valid. An edge seen while the record is still valid
// sets sticky capt_ovf and leaves the record alone. capt_ack clears valid/ovf; an
// edge arriving together with capt_ack starts a fresh capture.
// Ports:
//   clk, rst              : clock, async active-high reset
//   capt_in               : asynchronous capture strobe
//   capt_ack              : consumer acknowledge
//   rtc_sec, rtc_nsec     : live time from the core
//   capt_valid, capt_ovf  : record status
//   capt_sec, capt_nsec   : latched time
module rtc_capt_chan
    import rtc_pkg::*;
#(
    parameter int unsigned SEC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 capt_in,
    input  logic                 capt_ack,
    input  logic [SEC_WIDTH-1:0] rtc_sec,
    input  logic [31:0]          rtc_nsec,
    output logic                 capt_valid,
    output logic                 capt_ovf,
    output logic [SEC_WIDTH-1:0] capt_sec,
    output logic [31:0]          capt_nsec
);

    // [0],[1]: synchroniser stages; [2]: previous synchronised level for edge detect
    logic [2:0] sync_q;
    logic       rise;
    capt_rec_t  rec_q;
    capt_rec_t  rec_d;

    // Synchroniser and record registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            rec_q  <= '0;
        end else begin
            sync_q <= {sync_q[1:0], capt_in};
            rec_q  <= rec_d;
        end
    end

    // Capture / overflow / acknowledge update
    always_comb begin
        rise  = sync_q[1] & ~sync_q[2];
        rec_d = rec_q;
        if (rise) begin
            if (!rec_q.valid || capt_ack) begin
                rec_d.sec   = SEC_MAX_W'(rtc_sec);
                rec_d.nsec  = rtc_nsec;
                rec_d.valid = 1'b1;
                rec_d.ovf   = 1'b0;
            end else begin
                rec_d.ovf   = 1'b1;
            end
        end else if (capt_ack) begin
            rec_d.valid = 1'b0;
            rec_d.ovf   = 1'b0;
        end
    end

    assign capt_valid = rec_q.valid;
    assign capt_ovf   = rec_q.ovf;
    assign capt_sec   = rec_q.sec[SEC_WIDTH-1:0];
    assign capt_nsec  = rec_q.nsec;

    // Upper seconds bits are always zero for narrow counters
    if (SEC_WIDTH < SEC_MAX_W) begin : g_sec_pad
        logic unused_sec_pad;
        assign unused_sec_pad = ^rec_q.sec[SEC_MAX_W-1:SEC_WIDTH];
    end

endmodule

// File: rtl/rtc_tstamp_core.sv
// Real-time clock with fixed-point per-cycle increment, absolute time load,
// one-shot phase adjust, PPS output and optional timestamp capture channels.
// Optional feature macro: RTC_CAPTURE_EN (capture channels; outputs tied 0 otherwise).
// Ports:
//   clk, rst                              : clock, async active-high reset
//   timeset, timeset_sec, timeset_nsec    : absolute time load (nsec must be < 1e9)
//   timeset_err                           : one-cycle pulse on rejected load
//   adj_valid, adj_nsec                   : one-shot signed ns offset
//   incr_load, incr_val                   : new per-cycle increment (ns, fixed point)
//   rtc_sec, rtc_nsec, rtc_frac           : current time
//   pps_out                               : high during the first half of each second
//   capt_in, capt_ack                     : per-channel capture strobe / acknowledge
//   capt_valid, capt_ovf, capt_sec, capt_nsec : per-channel capture records (packed)
module rtc_tstamp_core
    import rtc_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 125_000_000,
    parameter int unsigned SEC_WIDTH       = 32,
    parameter int unsigned FRAC_WIDTH      = 16,
    parameter int unsigned NUM_CAPT        = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                timeset,
    input  logic [SEC_WIDTH-1:0]                timeset_sec,
    input  logic [31:0]                         timeset_nsec,
    output logic                                timeset_err,
    input  logic                                adj_valid,
    input  logic [31:0]                         adj_nsec,
    input  logic                                incr_load,
    input  logic [incr_width(FRAC_WIDTH)-1:0]   incr_val,
    output logic [SEC_WIDTH-1:0]                rtc_sec,
    output logic [31:0]                         rtc_nsec,
    output logic [FRAC_WIDTH-1:0]               rtc_frac,
    output logic                                pps_out,
    input  logic [NUM_CAPT-1:0]                 capt_in,
    input  logic [NUM_CAPT-1:0]                 capt_ack,
    output logic [NUM_CAPT-1:0]                 capt_valid,
    output logic [NUM_CAPT-1:0]                 capt_ovf,
    output logic [NUM_CAPT*SEC_WIDTH-1:0]       capt_sec,
    output logic [NUM_CAPT*32-1:0]              capt_nsec
);

    localparam int unsigned        INCR_W      = incr_width(FRAC_WIDTH);
    localparam logic [63:0]        INCR_RST_64 = (64'(NS_PER_SEC) << FRAC_WIDTH) / 64'(CLOCK_FREQUENCY);
    localparam logic [INCR_W-1:0]  INCR_RST    = INCR_W'(INCR_RST_64);
    localparam logic signed [33:0] NS_S        = 34'(NS_PER_SEC);
    localparam logic signed [33:0] NS2_S       = NS_S + NS_S;
    localparam logic signed [33:0] NEG_NS_S    = -NS_S;

    logic [SEC_WIDTH-1:0]  sec_q,  sec_d;
    logic [31:0]           nsec_q, nsec_d;
    logic [FRAC_WIDTH-1:0] frac_q, frac_d;
    logic [INCR_W-1:0]     incr_q, incr_d;
    logic                  err_d;
    logic                  pps_d;

    logic [FRAC_WIDTH:0]   frac_sum;
    logic signed [33:0]    adj_ext;
    logic signed [33:0]    adj_add;
    logic signed [33:0]    ns_sum;
    logic                  adj_ok;

    // Timebase registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_q       <= '0;
            nsec_q      <= '0;
            frac_q      <= '0;
            incr_q      <= INCR_RST;
            timeset_err <= 1'b0;
            pps_out     <= 1'b0;
        end else begin
            sec_q       <= sec_d;
            nsec_q      <= nsec_d;
            frac_q      <= frac_d;
            incr_q      <= incr_d;
            timeset_err <= err_d;
            pps_out     <= pps_d;
        end
    end

    // Next time: increment plus optional adjust, normalised into [0, 1e9); timeset overrides
    always_comb begin
        frac_sum = {1'b0, frac_q} + {1'b0, incr_q[FRAC_WIDTH-1:0]};
        adj_ext  = {{2{adj_nsec[31]}}, adj_nsec};
        // Out-of-range offsets are ignored; a concurrent timeset drops the adjust
        adj_ok   = adj_valid && !timeset && (adj_ext < NS_S) && (adj_ext > NEG_NS_S);
        adj_add  = adj_ok ? adj_ext : 34'sd0;
        ns_sum   = $signed(34'(nsec_q))
                 + $signed(34'(incr_q[INCR_W-1:FRAC_WIDTH]))
                 + $signed(34'(frac_sum[FRAC_WIDTH]))
                 + adj_add;

        sec_d  = sec_q;
        nsec_d = 32'(ns_sum);
        frac_d = frac_sum[FRAC_WIDTH-1:0];
        err_d  = 1'b0;
        incr_d = incr_load ? incr_val : incr_q;

        if (ns_sum < 34'sd0) begin
            nsec_d = 32'(ns_sum + NS_S);
            sec_d  = sec_q - SEC_WIDTH'(1);
        end else if (ns_sum >= NS2_S) begin
            // Only reachable with a near-maximal positive adjust at the top of a second
            nsec_d = 32'(ns_sum - NS2_S);
            sec_d  = sec_q + SEC_WIDTH'(2);
        end else if (ns_sum >= NS_S) begin
            nsec_d = 32'(ns_sum - NS_S);
            sec_d  = sec_q + SEC_WIDTH'(1);
        end

        if (timeset) begin
            if (timeset_nsec < NS_PER_SEC) begin
                sec_d  = timeset_sec;
                nsec_d = timeset_nsec;
                frac_d = '0;
            end else begin
                err_d  = 1'b1;
            end
        end

        // Registered from the next value so pps_out lines up with rtc_nsec
        pps_d = (nsec_d < NS_HALF_SEC);
    end

    assign rtc_sec  = sec_q;
    assign rtc_nsec = nsec_q;
    assign rtc_frac = frac_q;

`ifdef RTC_CAPTURE_EN
    // One capture channel per input
    for (genvar i = 0; i < NUM_CAPT; i++) begin : g_capt
        rtc_capt_chan #(
            .SEC_WIDTH(SEC_WIDTH)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .capt_in   (capt_in[i]),
            .capt_ack  (capt_ack[i]),
            .rtc_sec   (sec_q),
            .rtc_nsec  (nsec_q),
            .capt_valid(capt_valid[i]),
            .capt_ovf  (capt_ovf[i]),
            .capt_sec  (capt_sec[i*SEC_WIDTH +: SEC_WIDTH]),
            .capt_nsec (capt_nsec[i*32 +: 32])
        );
    end
`else
    assign capt_valid = '0;
    assign capt_ovf   = '0;
    assign capt_sec   = '0;
    assign capt_nsec  = '0;

    logic unused_capt;
    assign unused_capt = ^{capt_in, capt_ack};
`endif

endmodule

// File: tb/tb_rtc_tstamp_core.sv
// Directed bench for rtc_tstamp_core at default parameters (125 MHz, 8 ns/cycle).
module tb_rtc_tstamp_core;

    localparam int unsigned SW = 32;
    localparam int unsigned FW = 16;
    localparam int unsigned NC = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              timeset;
    logic [SW-1:0]     timeset_sec;
    logic [31:0]       timeset_nsec;
    logic              timeset_err;
    logic              adj_valid;
    logic [31:0]       adj_nsec;
    logic              incr_load;
    logic [FW+7:0]     incr_val;
    logic [SW-1:0]     rtc_sec;
    logic [31:0]       rtc_nsec;
    logic [FW-1:0]     rtc_frac;
    logic              pps_out;
    logic [NC-1:0]     capt_in;
    logic [NC-1:0]     capt_ack;
    logic [NC-1:0]     capt_valid;
    logic [NC-1:0]     capt_ovf;
    logic [NC*SW-1:0]  capt_sec;
    logic [NC*32-1:0]  capt_nsec;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rtc_tstamp_core dut (
        .clk         (clk),
        .rst         (rst),
        .timeset     (timeset),
        .timeset_sec (timeset_sec),
        .timeset_nsec(timeset_nsec),
        .timeset_err (timeset_err),
        .adj_valid   (adj_valid),
        .adj_nsec    (adj_nsec),
        .incr_load   (incr_load),
        .incr_val    (incr_val),
        .rtc_sec     (rtc_sec),
        .rtc_nsec    (rtc_nsec),
        .rtc_frac    (rtc_frac),
        .pps_out     (pps_out),
        .capt_in     (capt_in),
        .capt_ack    (capt_ack),
        .capt_valid  (capt_valid),
        .capt_ovf    (capt_ovf),
        .capt_sec    (capt_sec),
        .capt_nsec   (capt_nsec)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_time(input string tag, input logic [SW-1:0] s, input logic [31:0] ns);
        chk({tag, ".sec"},  64'(rtc_sec),  64'(s));
        chk({tag, ".nsec"}, 64'(rtc_nsec), 64'(ns));
    endtask

    task automatic do_timeset(input logic [SW-1:0] s, input logic [31:0] ns);
        timeset = 1'b1; timeset_sec = s; timeset_nsec = ns;
        step();
        timeset = 1'b0;
    endtask

    initial begin
        rst = 1'b1; timeset = 1'b0; timeset_sec = '0; timeset_nsec = '0;
        adj_valid = 1'b0; adj_nsec = '0; incr_load = 1'b0; incr_val = '0;
        capt_in = '0; capt_ack = '0;
        step(); step();

        // Reset state
        chk_time("reset", 32'd0, 32'd0);
        chk("reset.frac", 64'(rtc_frac), 64'd0);
        chk("reset.pps", 64'(pps_out), 64'd0);
        chk("reset.err", 64'(timeset_err), 64'd0);
        chk("reset.capt_valid", 64'(capt_valid), 64'd0);

        // Restart from zero with the 8 ns reset increment
        rst = 1'b0;
        step();
        chk_time("run1", 32'd0, 32'd8);
        chk("run1.pps", 64'(pps_out), 64'd1);
        step();
        chk_time("run2", 32'd0, 32'd16);

        // Timeset then second rollover
        do_timeset(32'd5, 32'd999_999_992);
        chk_time("ts5", 32'd5, 32'd999_999_992);
        chk("ts5.frac", 64'(rtc_frac), 64'd0);
        chk("ts5.pps", 64'(pps_out), 64'd0);
        step();
        chk_time("roll6", 32'd6, 32'd0);
        chk("roll6.pps", 64'(pps_out), 64'd1);

        // PPS half-second boundary
        do_timeset(32'd7, 32'd499_999_992);
        chk("pps.below", 64'(pps_out), 64'd1);
        step();
        chk_time("pps.edge", 32'd7, 32'd500_000_000);
        chk("pps.at_half", 64'(pps_out), 64'd0);

        // Negative adjust borrows a second: 100 + 8 - 200 = -92
        do_timeset(32'd3, 32'd100);
        chk_time("adj.base", 32'd3, 32'd100);
        adj_valid = 1'b1; adj_nsec = 32'hFFFF_FF38;
        step();
        adj_valid = 1'b0;
        chk_time("adj.neg", 32'd2, 32'd999_999_908);

        // Rejected timeset: error pulse, time keeps running
        timeset = 1'b1; timeset_sec = 32'd77; timeset_nsec = 32'd1_000_000_000;
        step();
        timeset = 1'b0;
        chk("tserr.pulse", 64'(timeset_err), 64'd1);
        chk_time("tserr.kept", 32'd2, 32'd999_999_916);
        step();
        chk("tserr.clear", 64'(timeset_err), 64'd0);
        chk_time("tserr.next", 32'd2, 32'd999_999_924);

        // |adj| = 1e9 is ignored
        adj_valid = 1'b1; adj_nsec = 32'd1_000_000_000;
        step();
        adj_valid = 1'b0;
        chk_time("adj.big", 32'd2, 32'd999_999_932);

        // Positive adjust carries: 999999932 + 8 + 100
        adj_valid = 1'b1; adj_nsec = 32'd100;
        step();
        adj_valid = 1'b0;
        chk_time("adj.pos", 32'd3, 32'd40);

        // Timeset wins over a concurrent adjust
        adj_valid = 1'b1; adj_nsec = 32'd5000;
        do_timeset(32'd10, 32'd1000);
        adj_valid = 1'b0;
        chk_time("ts_adj", 32'd10, 32'd1000);
        step();
        chk_time("ts_adj.next", 32'd10, 32'd1008);

        // Seconds wrap forward and backward
        do_timeset(32'hFFFF_FFFF, 32'd999_999_992);
        step();
        chk_time("wrap.fwd", 32'd0, 32'd0);
        do_timeset(32'd0, 32'd50);
        adj_valid = 1'b1; adj_nsec = 32'hFFFF_FF9C;
        step();
        adj_valid = 1'b0;
        chk_time("wrap.back", 32'hFFFF_FFFF, 32'd999_999_958);

        // 8.5 ns increment loaded together with a timeset
        incr_load = 1'b1; incr_val = 24'h08_8000;
        do_timeset(32'd20, 32'd0);
        incr_load = 1'b0;
        chk_time("incr.load", 32'd20, 32'd0);
        step();
        chk_time("incr.c1", 32'd20, 32'd8);
        chk("incr.c1.frac", 64'(rtc_frac), 64'h8000);
        step();
        chk_time("incr.c2", 32'd20, 32'd17);
        chk("incr.c2.frac", 64'(rtc_frac), 64'd0);
        step(); step();
        chk_time("incr.c4", 32'd20, 32'd34);
        incr_load = 1'b1; incr_val = 24'h08_0000;
        step();
        incr_load = 1'b0;
        chk_time("incr.back0", 32'd20, 32'd42);
        step();
        chk_time("incr.back1", 32'd20, 32'd50);
        chk("incr.back1.frac", 64'(rtc_frac), 64'h8000);

        incr_load = 1'b1; incr_val = 24'h08_0000;
        do_timeset(32'd30, 32'd0);
        incr_load = 1'b0;
`ifdef RTC_CAPTURE_EN
        // Capture on channel 2: edge driven after T0, latched at the third edge
        capt_in[2] = 1'b1;
        step();
        chk("capt.e1", 64'(capt_valid), 64'd0);
        step();
        chk("capt.e2", 64'(capt_valid), 64'd0);
        step();
        chk("capt.valid", 64'(capt_valid), 64'b0100);
        chk("capt.ovf0", 64'(capt_ovf), 64'd0);
        chk("capt.sec", 64'(capt_sec[2*SW +: SW]), 64'd30);
        chk("capt.nsec", 64'(capt_nsec[2*32 +: 32]), 64'd16);

        // Second edge before ack: sticky overflow, value held
        capt_in[2] = 1'b0;
        step(); step(); step();
        capt_in[2] = 1'b1;
        step(); step(); step();
        chk("ovf.flag", 64'(capt_ovf), 64'b0100);
        chk("ovf.valid", 64'(capt_valid), 64'b0100);
        chk("ovf.held", 64'(capt_nsec[2*32 +: 32]), 64'd16);

        // Edge together with ack recaptures
        capt_in[2] = 1'b0;
        step(); step(); step();
        capt_in[2] = 1'b1;
        step(); step();
        capt_ack[2] = 1'b1;
        step();
        capt_ack[2] = 1'b0;
        chk("reack.valid", 64'(capt_valid), 64'b0100);
        chk("reack.ovf", 64'(capt_ovf), 64'd0);
        chk("reack.nsec", 64'(capt_nsec[2*32 +: 32]), 64'd112);

        // Plain ack clears
        capt_ack[2] = 1'b1;
        step();
        capt_ack[2] = 1'b0;
        chk("ack.valid", 64'(capt_valid), 64'd0);
        chk("ack.ovf", 64'(capt_ovf), 64'd0);
`else
        // Capture compiled out: edges never produce a record
        capt_in = 4'hF;
        step(); step(); step(); step();
        chk("nocapt.valid", 64'(capt_valid), 64'd0);
        chk("nocapt.ovf", 64'(capt_ovf), 64'd0);
        chk("nocapt.nsec", 64'(capt_nsec), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
